// File: rtl/conv_layer1.sv
// LeNet-5 first convolution stage: captures one image, then per output channel runs a
// sequential K x K convolution, ReLU and P x P max-pool, one MAC per cycle.
module conv_layer1 #(
  parameter int unsigned mem_ifmap_addr_width = 10,
  parameter int unsigned mem_ifmap_bit_width  = 8,
  parameter int unsigned mem_ifmap_depth      = 784,
  parameter int unsigned I_SIZE               = 28,
  parameter int unsigned O_SIZE               = 12,
  parameter int unsigned I_BW                 = 8,
  parameter int unsigned W_BW                 = 8,
  parameter int unsigned O_BW                 = 8,
  parameter int unsigned O_CONV_BW            = 21,
  parameter int unsigned CI                   = 1,
  parameter int unsigned CO                   = 4,
  parameter int unsigned K_SIZE               = 5,
  parameter int unsigned P_SIZE               = 2,
  parameter int unsigned W_FRAC               = 7
) (
  input  logic                                   clk,
  input  logic                                   global_rst_n,
  input  logic                                   ce,
  input  logic                                   rst_processEnd,
  input  logic signed [I_BW-1:0]                 i_fmap,
  input  logic [CO*CI*K_SIZE*K_SIZE*W_BW-1:0]    i_weight,
  output logic [O_BW-1:0]                        o_conv1_result,
  output logic                                   o_convlayer1_en,
  output logic                                   o_convlayer1_ch_end,
  output logic                                   o_convlayer1_allch_end
);

  localparam int unsigned KW    = (K_SIZE > 1) ? $clog2(K_SIZE) : 1;
  localparam int unsigned PW    = (P_SIZE > 1) ? $clog2(P_SIZE) : 1;
  localparam int unsigned OW    = (O_SIZE > 1) ? $clog2(O_SIZE) : 1;
  localparam int unsigned CW    = (CO > 1) ? $clog2(CO) : 1;
  localparam int unsigned AW    = mem_ifmap_addr_width;
  localparam int unsigned KK    = K_SIZE * K_SIZE;
  localparam int unsigned PRODW = mem_ifmap_bit_width + W_BW;

  localparam logic [KW-1:0] KLast    = KW'(K_SIZE - 1);
  localparam logic [PW-1:0] PLast    = PW'(P_SIZE - 1);
  localparam logic [OW-1:0] OLast    = OW'(O_SIZE - 1);
  localparam logic [CW-1:0] CLast    = CW'(CO - 1);
  localparam logic [AW-1:0] AddrLast = AW'(mem_ifmap_depth - 1);
  localparam logic signed [O_CONV_BW-1:0] SatMax = O_CONV_BW'((2 ** (O_BW - 1)) - 1);

  typedef enum logic [1:0] {StCapture, StCompute, StDone} state_e;

  state_e                        state_q;
  logic [AW-1:0]                 addr_q;
  logic [KW-1:0]                 kr_q, kc_q;
  logic [PW-1:0]                 dy_q, dx_q;
  logic [OW-1:0]                 pr_q, pc_q;
  logic [CW-1:0]                 ch_q;
  logic                          out_phase_q;
  logic signed [O_CONV_BW-1:0]   acc_q, max_q;
  logic [O_BW-1:0]               result_q;
  logic                          en_q, ch_end_q, all_end_q;

  logic signed [mem_ifmap_bit_width-1:0] ifmap_mem [mem_ifmap_depth];

  int unsigned                   rd_row, rd_col, w_idx;
  logic [AW-1:0]                 rd_addr;
  logic signed [mem_ifmap_bit_width-1:0] pix;
  logic signed [W_BW-1:0]        w_tap;
  logic signed [PRODW-1:0]       prod;
  logic signed [O_CONV_BW-1:0]   conv_d, pool_d, shifted;
  logic [O_BW-1:0]               res_d;

  always_ff @(posedge clk) begin
    if (global_rst_n && !rst_processEnd && state_q == StCapture && ce) begin
      ifmap_mem[addr_q] <= mem_ifmap_bit_width'(i_fmap);
    end
  end

  always_comb begin
    rd_row  = 32'(pr_q) * P_SIZE + 32'(dy_q) + 32'(kr_q);
    rd_col  = 32'(pc_q) * P_SIZE + 32'(dx_q) + 32'(kc_q);
    rd_addr = AW'(rd_row * I_SIZE + rd_col);
    pix     = ifmap_mem[rd_addr];
    w_idx   = 32'(ch_q) * KK + 32'(kr_q) * K_SIZE + 32'(kc_q);
    w_tap   = $signed(i_weight[w_idx*W_BW +: W_BW]);
    prod    = PRODW'(pix) * PRODW'(w_tap);
    conv_d  = acc_q + O_CONV_BW'(prod);
    // First window position seeds the pool maximum.
    pool_d  = ((dy_q == '0 && dx_q == '0) || conv_d > max_q) ? conv_d : max_q;
    shifted = max_q >>> W_FRAC;
    if (max_q[O_CONV_BW-1]) begin
      res_d = '0;
    end else if (shifted > SatMax) begin
      res_d = O_BW'(SatMax);
    end else begin
      res_d = O_BW'(shifted);
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q <= StCapture;  addr_q <= '0;  kr_q <= '0;  kc_q <= '0;
      dy_q <= '0;  dx_q <= '0;  pr_q <= '0;  pc_q <= '0;  ch_q <= '0;
      out_phase_q <= 1'b0;  acc_q <= '0;  max_q <= '0;  result_q <= '0;
      en_q <= 1'b0;  ch_end_q <= 1'b0;  all_end_q <= 1'b0;
    end else if (rst_processEnd) begin
      state_q <= StCapture;  addr_q <= '0;  kr_q <= '0;  kc_q <= '0;
      dy_q <= '0;  dx_q <= '0;  pr_q <= '0;  pc_q <= '0;  ch_q <= '0;
      out_phase_q <= 1'b0;  acc_q <= '0;  max_q <= '0;  result_q <= '0;
      en_q <= 1'b0;  ch_end_q <= 1'b0;  all_end_q <= 1'b0;
    end else begin
      en_q      <= 1'b0;
      ch_end_q  <= 1'b0;
      all_end_q <= 1'b0;
      unique case (state_q)
        StCapture: begin
          if (ce) begin
            addr_q <= addr_q + 1'b1;
            if (addr_q == AddrLast) begin
              addr_q  <= '0;
              state_q <= StCompute;
            end
          end
        end
        StCompute: begin
          if (out_phase_q) begin
            out_phase_q <= 1'b0;
            result_q    <= res_d;
            en_q        <= 1'b1;
            if (pc_q == OLast) begin
              pc_q <= '0;
              if (pr_q == OLast) begin
                pr_q     <= '0;
                ch_end_q <= 1'b1;
                if (ch_q == CLast) begin
                  all_end_q <= 1'b1;
                  state_q   <= StDone;
                end else begin
                  ch_q <= ch_q + 1'b1;
                end
              end else begin
                pr_q <= pr_q + 1'b1;
              end
            end else begin
              pc_q <= pc_q + 1'b1;
            end
          end else begin
            acc_q <= conv_d;
            if (kc_q == KLast) begin
              kc_q <= '0;
              if (kr_q == KLast) begin
                kr_q  <= '0;
                acc_q <= '0;
                max_q <= pool_d;
                if (dx_q == PLast) begin
                  dx_q <= '0;
                  if (dy_q == PLast) begin
                    dy_q        <= '0;
                    out_phase_q <= 1'b1;
                  end else begin
                    dy_q <= dy_q + 1'b1;
                  end
                end else begin
                  dx_q <= dx_q + 1'b1;
                end
              end else begin
                kr_q <= kr_q + 1'b1;
              end
            end else begin
              kc_q <= kc_q + 1'b1;
            end
          end
        end
        StDone: begin
          result_q <= '0;
        end
        default: state_q <= StCapture;
      endcase
    end
  end

  assign o_conv1_result         = result_q;
  assign o_convlayer1_en        = en_q;
  assign o_convlayer1_ch_end    = ch_end_q;
  assign o_convlayer1_allch_end = all_end_q;

endmodule

// File: tb/tb_conv_layer1.sv
// Directed-vector bench for conv_layer1: framing, ReLU, saturation, pooling, restarts.
module tb_conv_layer1;

  localparam int NPIX = 784;
  localparam int ISZ  = 28;
  localparam int NOUT = 144;
  localparam int NCH  = 4;
  localparam int KK   = 25;
  localparam int PER  = 101;

  logic              clk = 1'b0;
  logic              global_rst_n;
  logic              ce;
  logic              rst_processEnd;
  logic signed [7:0] i_fmap;
  logic [NCH*KK*8-1:0] i_weight;
  logic [7:0]        o_conv1_result;
  logic              o_convlayer1_en;
  logic              o_convlayer1_ch_end;
  logic              o_convlayer1_allch_end;

  conv_layer1 dut (
    .clk                    (clk),
    .global_rst_n           (global_rst_n),
    .ce                     (ce),
    .rst_processEnd         (rst_processEnd),
    .i_fmap                 (i_fmap),
    .i_weight               (i_weight),
    .o_conv1_result         (o_conv1_result),
    .o_convlayer1_en        (o_convlayer1_en),
    .o_convlayer1_ch_end    (o_convlayer1_ch_end),
    .o_convlayer1_allch_end (o_convlayer1_allch_end)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         errs = 0;
  int         checks = 0;
  int         stray = 0;
  bit         toggle_ce = 1'b0;
  int         last_wr;
  int         prev;
  logic [7:0] img [NPIX];
  int         exp_a [NCH] = '{25, 0, 0, 99};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_w(input int c, input int k, input logic [7:0] v);
    i_weight[(c*KK+k)*8 +: 8] = v;
  endtask

  // Streams img[]; a ce=0 bubble carrying junk precedes every gap-th pixel when gap != 0.
  task automatic stream(input int gap);
    for (int p = 0; p < NPIX; p++) begin
      if (gap != 0 && p % gap == 0) begin
        ce = 1'b0;
        i_fmap = 8'sh55;
        @(negedge clk);
      end
      ce = 1'b1;
      i_fmap = img[p];
      last_wr = cyc + 1;
      @(negedge clk);
    end
    ce = 1'b0;
  endtask

  task automatic wait_en(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (toggle_ce) begin
        ce = 1'($urandom_range(0, 1));
        i_fmap = 8'($urandom);
      end
      if (o_convlayer1_en) begin
        ok = 1'b1;
        break;
      end
      if (o_convlayer1_ch_end || o_convlayer1_allch_end) stray++;
    end
  endtask

  task automatic restart();
    ce = 1'b0;
    rst_processEnd = 1'b1;
    @(negedge clk);
    rst_processEnd = 1'b0;
    check_eq("restart_en", o_convlayer1_en, 0);
    check_eq("restart_res", o_conv1_result, 0);
  endtask

  initial begin
    bit ok;
    int cnt;
    global_rst_n = 1'b0;
    ce = 1'b0;
    rst_processEnd = 1'b0;
    i_fmap = '0;
    i_weight = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_res", o_conv1_result, 0);
    check_eq("reset_en", o_convlayer1_en, 0);
    check_eq("reset_chend", o_convlayer1_ch_end, 0);
    check_eq("reset_allend", o_convlayer1_allch_end, 0);
    global_rst_n = 1'b1;
    @(negedge clk);

    // Full run: uniform image, per-channel ReLU behaviour, framing, ce ignored in compute.
    for (int p = 0; p < NPIX; p++) img[p] = 8'd4;
    for (int k = 0; k < KK; k++) begin
      set_w(0, k, 8'd32);
      set_w(1, k, 8'hE0);
      set_w(2, k, 8'd0);
      set_w(3, k, 8'd127);
    end
    stream(0);
    prev = last_wr;
    toggle_ce = 1'b1;
    for (int n = 0; n < NCH*NOUT; n++) begin
      wait_en(PER + 50, ok);
      if (!ok) begin
        check_eq("A_timeout", 0, 1);
        break;
      end
      check_eq($sformatf("A_gap%0d", n), cyc - prev, PER);
      prev = cyc;
      check_eq($sformatf("A_res%0d", n), o_conv1_result, exp_a[n/NOUT]);
      check_eq($sformatf("A_chend%0d", n), o_convlayer1_ch_end, (n % NOUT == NOUT-1));
      check_eq($sformatf("A_allend%0d", n), o_convlayer1_allch_end, (n == NCH*NOUT-1));
    end
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      ce = 1'($urandom_range(0, 1));
      if (o_convlayer1_en || o_convlayer1_ch_end || o_convlayer1_allch_end) cnt++;
    end
    toggle_ce = 1'b0;
    check_eq("A_done_idle", cnt, 0);
    check_eq("A_stray", stray, 0);

    // Saturation.
    restart();
    i_weight = '0;
    for (int p = 0; p < NPIX; p++) img[p] = 8'd127;
    for (int k = 0; k < KK; k++) set_w(0, k, 8'd127);
    stream(0);
    wait_en(PER + 50, ok);
    check_eq("B_found", ok, 1);
    check_eq("B_gap", cyc - last_wr, PER);
    check_eq("B_res", o_conv1_result, 127);

    // Max-pool over column ramp, captured with ce bubbles.
    restart();
    i_weight = '0;
    set_w(0, 0, 8'd127);
    for (int r = 0; r < ISZ; r++)
      for (int x = 0; x < ISZ; x++) img[r*ISZ+x] = 8'(x);
    stream(3);
    prev = last_wr;
    for (int pc = 0; pc < 12; pc++) begin
      wait_en(PER + 50, ok);
      check_eq($sformatf("C_found%0d", pc), ok, 1);
      check_eq($sformatf("C_gap%0d", pc), cyc - prev, PER);
      prev = cyc;
      check_eq($sformatf("C_res%0d", pc), o_conv1_result, 2*pc);
    end

    // Restart mid-compute, new image r+x with a single off-origin tap.
    restart();
    i_weight = '0;
    set_w(0, 6, 8'd64);
    for (int r = 0; r < ISZ; r++)
      for (int x = 0; x < ISZ; x++) img[r*ISZ+x] = 8'(r + x);
    stream(0);
    prev = last_wr;
    for (int n = 0; n < 14; n++) begin
      wait_en(PER + 50, ok);
      check_eq($sformatf("D_found%0d", n), ok, 1);
      check_eq($sformatf("D_gap%0d", n), cyc - prev, PER);
      prev = cyc;
      check_eq($sformatf("D_res%0d", n), o_conv1_result, (n < 12) ? n + 2 : n - 9);
    end

    // Asynchronous reset in the middle of compute.
    global_rst_n = 1'b0;
    #1;
    check_eq("E_res", o_conv1_result, 0);
    check_eq("E_en", o_convlayer1_en, 0);
    check_eq("E_chend", o_convlayer1_ch_end, 0);
    check_eq("E_allend", o_convlayer1_allch_end, 0);
    @(negedge clk);
    global_rst_n = 1'b1;
    @(negedge clk);
    stream(0);
    wait_en(PER + 50, ok);
    check_eq("E_found", ok, 1);
    check_eq("E_gap", cyc - last_wr, PER);
    check_eq("E_res0", o_conv1_result, 2);
    check_eq("E_chend0", o_convlayer1_ch_end, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/conv_layer1.md
Name: conv_layer1

Overview:
- First convolution stage of the LeNet-5 accelerator.
- Captures one single-channel I_SIZE×I_SIZE image streamed one pixel per cycle, then computes CO channels in turn. Each channel is a valid K_SIZE×K_SIZE convolution, followed by ReLU and P_SIZE×P_SIZE max-pool.
- Emits a channel-serial stream of O_SIZE×O_SIZE pooled results, which feeds conv_layer2 directly (its ce = o_convlayer1_en, its ch_end = o_convlayer1_ch_end).

Parameters:
mem_ifmap_addr_width, 10, address width of internal image memory
mem_ifmap_bit_width, 8, word width of image memory (= I_BW)
mem_ifmap_depth, 784, image memory depth (= I_SIZE*I_SIZE)
I_SIZE, 28, input image side
O_SIZE, 12, pooled output side (= (I_SIZE-K_SIZE+1)/P_SIZE)
I_BW, 8, signed input pixel width
W_BW, 8, signed weight width (Q1.7)
O_BW, 8, output width
O_CONV_BW, 21, signed accumulator width (I_BW+W_BW+5)
CI, 1, input channels (fixed 1)
CO, 4, output channels
K_SIZE, 5, kernel side
P_SIZE, 2, pool side
W_FRAC, 7, weight fraction bits (output right shift)

Ports:
clk  in  1  clock
global_rst_n  in  1  asynchronous active-low reset
ce  in  1  pixel valid / capture enable
rst_processEnd  in  1  synchronous restart for next image
i_fmap  in  I_BW  signed pixel, raster order
i_weight  in  CO*K_SIZE*K_SIZE*W_BW  packed kernels
o_conv1_result  out  O_BW  pooled result
o_convlayer1_en  out  1  result valid strobe
o_convlayer1_ch_end  out  1  last result of a channel
o_convlayer1_allch_end  out  1  last result of last channel

Behaviour:
- Reset: already decided as global_rst_n asynchronous active-low, clock clk. Reset clears all outputs, counters and state to 0 and enters CAPTURE. Image memory contents need no reset.
- rst_processEnd high at a clock edge: same effect as reset, except memory contents are kept. It has priority over ce.
- States: CAPTURE, COMPUTE, DONE.
- CAPTURE:
  - Each cycle with ce=1 writes i_fmap to mem[addr] and increments addr. ce=0 holds.
  - After I_SIZE*I_SIZE writes, go to COMPUTE.
  - ce in COMPUTE or DONE is ignored.
- Weight indexing: kernel c, tap k=row*K_SIZE+col sits at i_weight[(c*K_SIZE*K_SIZE+k)*W_BW +: W_BW]. i_weight must stay stable from COMPUTE entry to DONE.
- Compute order: channel c=0..CO-1, then pooled row pr, then pooled col pc, all raster.
- For each output, conv(r,x) = signed sum over the kernel of mem[(r+i)*I_SIZE+x+j]*w[c][i*K+j], full precision in O_CONV_BW. Evaluate it at r=P_SIZE*pr+dy, x=P_SIZE*pc+dx for dy,dx in 0..P_SIZE-1.
- pooled = max of the 4 conv values. Result = 0 if pooled<0. Otherwise take pooled>>>W_FRAC and saturate to 2^(O_BW-1)-1.
- Timing:
  - One MAC per cycle, so each output costs P_SIZE*P_SIZE*K_SIZE*K_SIZE = 100 MAC cycles plus 1 output cycle.
  - The first o_convlayer1_en occurs 101 cycles after the edge that writes the last pixel. Successive strobes are exactly 101 cycles apart, including across channel boundaries.
- Output strobes:
  - o_convlayer1_en: 1-cycle pulse with o_conv1_result valid.
  - o_convlayer1_ch_end: pulses coincident with the en of output index O_SIZE*O_SIZE-1 of each channel.
  - o_convlayer1_allch_end: pulses coincident with the last channel's ch_end.
  - Then enter DONE, which is idle with outputs 0 until rst_processEnd.
- o_conv1_result holds its last value between strobes; it is 0 after reset.

Test Plan:
- Reset mid-COMPUTE: assert global_rst_n low → all outputs 0 at once. Then restream 784 pixels → the en sequence restarts from channel 0.
- All pixels 4; w0 all 32, w1 all −32, w2 all 0, w3 all 127 → channel 0 outputs 25 (3200>>7), channel 1 outputs 0 (ReLU), channel 2 outputs 0. Channel 3 computes 12700>>7 = 99.
- Saturation: pixels all 127, w0 all 127 → channel 0 outputs 127 (saturated).
- Max-pool: pixel(r,x)=x, w0 only k=0 =127 → channel 0 output(pr,pc)=((2pc+1)*127)>>7=2pc, e.g. pc=5 → 10.
- Framing: count strobes → exactly 576 en, 4 ch_end (at en #144, #288, #432, #576), 1 allch_end with the last. Spacing is 101 cycles; ce toggling during COMPUTE has no effect.
- Capture gaps plus restart: stream 784 pixels with ce=0 bubbles → the first en comes 101 cycles after the last accepted pixel. rst_processEnd then a new image → the full sequence repeats.
